// File: rtl/aux_memory_ctrl.sv
// aux_memory_ctrl: scratch/golden store for the PMBIST engine.
// Single-port behavioural RAM behind a valid/ready command port supporting
// WRITE, READ and READ_CMP, an RD_LAT-cycle read pipeline, and sticky compare
// error status (flag, saturating count, first failing address).
// Optional build macro AUXMEM_INIT_CLEAR_EN: zero the whole array after reset
// release (INIT state) before commands are accepted.
module aux_memory_ctrl #(
    parameter int unsigned DW     = 8,
    parameter int unsigned AW     = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned ECW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_in,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          rd_valid,
    output logic          cmp_fail,
    output logic          err_flag,
    output logic [ECW-1:0] err_cnt,
    output logic [AW-1:0] fail_addr,
    input  logic          clr_err
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_RDCMP = 2'b11;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_INIT  = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   ready_nxt;

    logic [DW-1:0] mem [DEPTH];

    logic          accept;
    logic          wr_acc;
    logic          rd_acc;
    logic          addr_ok;
    logic [IW-1:0] mem_idx;
    logic [DW-1:0] rd_word;

    logic          exit_vld;
    logic          exit_cmp;
    logic [DW-1:0] exit_data;
    logic [DW-1:0] exit_exp;
    logic [AW-1:0] exit_addr;
    logic          mismatch;

`ifdef AUXMEM_INIT_CLEAR_EN
    logic [IW-1:0] init_addr;
    logic          init_last;
    logic          init_we;

    assign init_last = (init_addr == IW'(DEPTH - 1));
`endif

    assign accept  = cmd_valid & cmd_ready;
    assign wr_acc  = accept && (cmd_in == CMD_WRITE);
    assign rd_acc  = accept && ((cmd_in == CMD_READ) || (cmd_in == CMD_RDCMP));
    assign addr_ok = ({1'b0, addr_in} < (AW + 1)'(DEPTH));
    assign mem_idx = IW'(addr_in);
    // Out-of-range addresses read as zero
    assign rd_word = addr_ok ? mem[mem_idx] : '0;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
`ifdef AUXMEM_INIT_CLEAR_EN
            ST_RESET: state_nxt = ST_INIT;
            ST_INIT:  if (init_last) state_nxt = ST_IDLE;
`else
            ST_RESET: state_nxt = ST_IDLE;
`endif
            ST_IDLE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_RESET;
        endcase
    end

    // FSM outputs: ready tracks the upcoming state so it can be registered
    always_comb begin
        ready_nxt = 1'b0;
`ifdef AUXMEM_INIT_CLEAR_EN
        init_we = 1'b0;
        if (state == ST_INIT) init_we = 1'b1;
`endif
        if (state_nxt == ST_IDLE) ready_nxt = 1'b1;
    end

    // Registered command ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_ready <= 1'b0;
        end else begin
            cmd_ready <= ready_nxt;
        end
    end

`ifdef AUXMEM_INIT_CLEAR_EN
    // Clear-sweep address; reset restarts the sweep at word 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_addr <= '0;
        end else if (init_we) begin
            init_addr <= init_addr + IW'(1);
        end
    end
`endif

    // Memory array write port (contents are not reset)
    always_ff @(posedge clk) begin
`ifdef AUXMEM_INIT_CLEAR_EN
        if (init_we) begin
            mem[init_addr] <= '0;
        end else if (wr_acc && addr_ok) begin
            mem[mem_idx] <= data_in;
        end
`else
        if (wr_acc && addr_ok) begin
            mem[mem_idx] <= data_in;
        end
`endif
    end

    // Read pipeline: data is captured at accept, RD_LAT-1 stages precede the output registers
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign exit_vld  = rd_acc;
            assign exit_cmp  = (cmd_in == CMD_RDCMP);
            assign exit_data = rd_word;
            assign exit_exp  = data_in;
            assign exit_addr = addr_in;
        end else begin : g_latn
            logic [RD_LAT-2:0] p_vld;
            logic [RD_LAT-2:0] p_cmp;
            logic [DW-1:0]     p_data [RD_LAT-1];
            logic [DW-1:0]     p_exp  [RD_LAT-1];
            logic [AW-1:0]     p_addr [RD_LAT-1];

            // Shift read requests towards the output; reset flushes in-flight reads
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    p_vld <= '0;
                    p_cmp <= '0;
                    for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
                        p_data[i] <= '0;
                        p_exp[i]  <= '0;
                        p_addr[i] <= '0;
                    end
                end else begin
                    p_vld[0]  <= rd_acc;
                    p_cmp[0]  <= (cmd_in == CMD_RDCMP);
                    p_data[0] <= rd_word;
                    p_exp[0]  <= data_in;
                    p_addr[0] <= addr_in;
                    for (int i = 1; i < int'(RD_LAT) - 1; i++) begin
                        p_vld[i]  <= p_vld[i-1];
                        p_cmp[i]  <= p_cmp[i-1];
                        p_data[i] <= p_data[i-1];
                        p_exp[i]  <= p_exp[i-1];
                        p_addr[i] <= p_addr[i-1];
                    end
                end
            end

            assign exit_vld  = p_vld[RD_LAT-2];
            assign exit_cmp  = p_cmp[RD_LAT-2];
            assign exit_data = p_data[RD_LAT-2];
            assign exit_exp  = p_exp[RD_LAT-2];
            assign exit_addr = p_addr[RD_LAT-2];
        end
    endgenerate

    assign mismatch = exit_vld & exit_cmp & (exit_data != exit_exp);

    // Read result registers; data_out holds between reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
            cmp_fail <= 1'b0;
        end else begin
            rd_valid <= exit_vld;
            cmp_fail <= mismatch;
            if (exit_vld) data_out <= exit_data;
        end
    end

    // Sticky error status; a mismatch takes priority over a coincident clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_flag  <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
        end else if (mismatch) begin
            err_flag <= 1'b1;
            if (clr_err) begin
                err_cnt   <= ECW'(1);
                fail_addr <= exit_addr;
            end else begin
                if (err_cnt != '1) err_cnt <= err_cnt + ECW'(1);
                if (!err_flag) fail_addr <= exit_addr;
            end
        end else if (clr_err) begin
            err_flag  <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
        end
    end

endmodule

// File: tb/tb_aux_memory_ctrl.sv
// Bench for aux_memory_ctrl: a default instance (RD_LAT=1, DEPTH=256, ECW=8)
// and a second instance (RD_LAT=3, DEPTH=200, ECW=2) share command stimulus.
// Expected reads are queued at issue time and retired by a cycle-based model.
module tb_aux_memory_ctrl;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] WR  = 2'b01;
    localparam logic [1:0] RD  = 2'b10;
    localparam logic [1:0] RC  = 2'b11;

    typedef struct packed {
        int         due;
        logic [7:0] data;
        logic       fail;
        logic [7:0] addr;
    } rd_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_in = 2'b00;
    logic [7:0] addr_in = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       clr1 = 1'b0;
    logic       clr2 = 1'b0;

    logic       rdy1, rv1, cf1, ef1;
    logic [7:0] dout1, ec1, fa1;
    logic       rdy2, rv2, cf2, ef2;
    logic [7:0] dout2, fa2;
    logic [1:0] ec2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] m1 [256];
    logic [7:0] m2 [200];
    rd_t pend1[$];
    rd_t pend2[$];

    logic       m_rdy = 1'b0;
    logic       m_rv1 = 1'b0, m_cf1 = 1'b0, m_ef1 = 1'b0;
    logic [7:0] m_do1 = 8'h00, m_ec1 = 8'h00, m_fa1 = 8'h00;
    logic       m_rv2 = 1'b0, m_cf2 = 1'b0, m_ef2 = 1'b0;
    logic [7:0] m_do2 = 8'h00, m_fa2 = 8'h00;
    logic [1:0] m_ec2 = 2'd0;

    aux_memory_ctrl u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
        .cmd_in(cmd_in), .addr_in(addr_in), .data_in(data_in),
        .data_out(dout1), .rd_valid(rv1), .cmp_fail(cf1), .err_flag(ef1),
        .err_cnt(ec1), .fail_addr(fa1), .clr_err(clr1)
    );

    aux_memory_ctrl #(.DW(8), .AW(8), .DEPTH(200), .RD_LAT(3), .ECW(2)) u_dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy2),
        .cmd_in(cmd_in), .addr_in(addr_in), .data_in(data_in),
        .data_out(dout2), .rd_valid(rv2), .cmp_fail(cf2), .err_flag(ef2),
        .err_cnt(ec2), .fail_addr(fa2), .clr_err(clr2)
    );

    always #5 clk = ~clk;

    // Reference model: retire queued reads at their due edge and track error status
    always @(posedge clk) begin
        rd_t e;
        logic f;
        cyc = cyc + 1;
        if (!rst) begin
            pend1.delete();
            pend2.delete();
            m_rdy = 1'b0;
            m_rv1 = 1'b0; m_cf1 = 1'b0; m_ef1 = 1'b0; m_do1 = 8'h00; m_ec1 = 8'h00; m_fa1 = 8'h00;
            m_rv2 = 1'b0; m_cf2 = 1'b0; m_ef2 = 1'b0; m_do2 = 8'h00; m_ec2 = 2'd0;  m_fa2 = 8'h00;
        end else begin
            m_rdy = 1'b1;
            m_rv1 = 1'b0; m_cf1 = 1'b0; f = 1'b0;
            if (pend1.size() > 0 && pend1[0].due == cyc) begin
                e = pend1.pop_front();
                m_rv1 = 1'b1; m_do1 = e.data; m_cf1 = e.fail; f = e.fail;
            end
            if (f) begin
                if (clr1) begin
                    m_ec1 = 8'd1; m_fa1 = e.addr;
                end else begin
                    if (m_ec1 != 8'hFF) m_ec1 = m_ec1 + 8'd1;
                    if (!m_ef1) m_fa1 = e.addr;
                end
                m_ef1 = 1'b1;
            end else if (clr1) begin
                m_ef1 = 1'b0; m_ec1 = 8'h00; m_fa1 = 8'h00;
            end
            m_rv2 = 1'b0; m_cf2 = 1'b0; f = 1'b0;
            if (pend2.size() > 0 && pend2[0].due == cyc) begin
                e = pend2.pop_front();
                m_rv2 = 1'b1; m_do2 = e.data; m_cf2 = e.fail; f = e.fail;
            end
            if (f) begin
                if (clr2) begin
                    m_ec2 = 2'd1; m_fa2 = e.addr;
                end else begin
                    if (m_ec2 != 2'd3) m_ec2 = m_ec2 + 2'd1;
                    if (!m_ef2) m_fa2 = e.addr;
                end
                m_ef2 = 1'b1;
            end else if (clr2) begin
                m_ef2 = 1'b0; m_ec2 = 2'd0; m_fa2 = 8'h00;
            end
        end
    end

    // Scoreboard compare every cycle outside reset
    always @(negedge clk) begin
        if (rst) begin
            n_cmp = n_cmp + 1;
            if ({rv1, cf1, dout1} !== {m_rv1, m_cf1, m_do1}) begin
                n_err = n_err + 1;
                $display("FAIL sb_read1 cyc=%0d got rv=%0b cf=%0b do=%02h exp rv=%0b cf=%0b do=%02h",
                         cyc, rv1, cf1, dout1, m_rv1, m_cf1, m_do1);
            end
            n_cmp = n_cmp + 1;
            if ({ef1, ec1, fa1} !== {m_ef1, m_ec1, m_fa1}) begin
                n_err = n_err + 1;
                $display("FAIL sb_err1 cyc=%0d got flag=%0b cnt=%0d fa=%02h exp flag=%0b cnt=%0d fa=%02h",
                         cyc, ef1, ec1, fa1, m_ef1, m_ec1, m_fa1);
            end
            n_cmp = n_cmp + 1;
            if ({rv2, cf2, dout2} !== {m_rv2, m_cf2, m_do2}) begin
                n_err = n_err + 1;
                $display("FAIL sb_read2 cyc=%0d got rv=%0b cf=%0b do=%02h exp rv=%0b cf=%0b do=%02h",
                         cyc, rv2, cf2, dout2, m_rv2, m_cf2, m_do2);
            end
            n_cmp = n_cmp + 1;
            if ({ef2, ec2, fa2} !== {m_ef2, m_ec2, m_fa2}) begin
                n_err = n_err + 1;
                $display("FAIL sb_err2 cyc=%0d got flag=%0b cnt=%0d fa=%02h exp flag=%0b cnt=%0d fa=%02h",
                         cyc, ef2, ec2, fa2, m_ef2, m_ec2, m_fa2);
            end
            n_cmp = n_cmp + 1;
            if ({rdy1, rdy2} !== {m_rdy, m_rdy}) begin
                n_err = n_err + 1;
                $display("FAIL sb_ready cyc=%0d got %0b%0b exp %0b%0b", cyc, rdy1, rdy2, m_rdy, m_rdy);
            end
        end
    end

    // Drive one command at the next negedge (after ready) and queue expected reads
    task automatic issue(input logic [1:0] c, input logic [7:0] a, input logic [7:0] d);
        rd_t e;
        logic [7:0] r1, r2;
        int g;
        g = 0;
        @(negedge clk);
        while (!(rdy1 && rdy2) && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!(rdy1 && rdy2)) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL ready_wait got %0b%0b exp 11", rdy1, rdy2);
        end
        cmd_valid = 1'b1; cmd_in = c; addr_in = a; data_in = d;
        if (c == WR) begin
            m1[a] = d;
            if (a < 8'd200) m2[a] = d;
        end else if (c == RD || c == RC) begin
            r1 = m1[a];
            r2 = (a < 8'd200) ? m2[a] : 8'h00;
            e.due = cyc + 1; e.data = r1; e.fail = (c == RC) && (r1 != d); e.addr = a;
            pend1.push_back(e);
            e.due = cyc + 3; e.data = r2; e.fail = (c == RC) && (r2 != d); e.addr = a;
            pend2.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) until every queued read has been retired
    task automatic drain();
        int g;
        g = 0;
        while ((pend1.size() != 0 || pend2.size() != 0) && g < 50) begin
            @(negedge clk);
            g++;
        end
        n_cmp = n_cmp + 1;
        if (pend1.size() != 0 || pend2.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL drain got pending %0d/%0d exp 0/0", pend1.size(), pend2.size());
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp = n_cmp + 1;
        if ({rdy1, rv1, cf1, ef1, dout1, ec1, fa1} !== 28'h0) begin
            n_err = n_err + 1;
            $display("FAIL reset_out1 got rdy=%0b rv=%0b cf=%0b ef=%0b do=%02h ec=%02h fa=%02h exp all 0",
                     rdy1, rv1, cf1, ef1, dout1, ec1, fa1);
        end
        n_cmp = n_cmp + 1;
        if ({rdy2, rv2, cf2, ef2, dout2, ec2, fa2} !== 22'h0) begin
            n_err = n_err + 1;
            $display("FAIL reset_out2 got rdy=%0b rv=%0b cf=%0b ef=%0b do=%02h ec=%0d fa=%02h exp all 0",
                     rdy2, rv2, cf2, ef2, dout2, ec2, fa2);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp = n_cmp + 1;
        if (rdy1 !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL ready_at_release got %0b exp 0", rdy1);
        end
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if ({rdy1, rdy2} !== 2'b11) begin
            n_err = n_err + 1;
            $display("FAIL ready_after_first_clock got %0b%0b exp 11", rdy1, rdy2);
        end
    endtask

    task automatic test_write_read();
        issue(WR, 8'h10, 8'h5A);
        issue(RD, 8'h10, 8'h00);
        issue(NOP, 8'h10, 8'hEE);
        n_cmp = n_cmp + 1;
        if ({rv1, dout1, cf1} !== {1'b1, 8'h5A, 1'b0}) begin
            n_err = n_err + 1;
            $display("FAIL write_read got rv=%0b do=%02h cf=%0b exp rv=1 do=5a cf=0", rv1, dout1, cf1);
        end
        idle();
        drain();
        n_cmp = n_cmp + 1;
        if (dout2 !== 8'h5A) begin
            n_err = n_err + 1;
            $display("FAIL write_read_lat3 got %02h exp 5a", dout2);
        end
    endtask

    task automatic test_read_cmp();
        issue(RC, 8'h10, 8'hA5);
        issue(WR, 8'h20, 8'h33);
        issue(RC, 8'h20, 8'h00);
        idle();
        drain();
        n_cmp = n_cmp + 1;
        if ({ef1, ec1, fa1} !== {1'b1, 8'd2, 8'h10}) begin
            n_err = n_err + 1;
            $display("FAIL read_cmp1 got flag=%0b cnt=%0d fa=%02h exp flag=1 cnt=2 fa=10", ef1, ec1, fa1);
        end
        n_cmp = n_cmp + 1;
        if ({ef2, ec2, fa2} !== {1'b1, 2'd2, 8'h10}) begin
            n_err = n_err + 1;
            $display("FAIL read_cmp2 got flag=%0b cnt=%0d fa=%02h exp flag=1 cnt=2 fa=10", ef2, ec2, fa2);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'd2; exp_seq[1] = 8'd3; exp_seq[2] = 8'd4;
        for (int i = 0; i < 4; i++) issue(WR, 8'(i), 8'(i + 1));
        for (int i = 0; i < 4; i++) issue(RD, 8'(i), 8'h00);
        idle();
        for (int i = 0; i < 3; i++) begin
            n_cmp = n_cmp + 1;
            if ({rv2, dout2} !== {1'b1, exp_seq[i]}) begin
                n_err = n_err + 1;
                $display("FAIL b2b_beat%0d got rv=%0b do=%02h exp rv=1 do=%02h", i + 1, rv2, dout2, exp_seq[i]);
            end
            @(negedge clk);
        end
        n_cmp = n_cmp + 1;
        if (rv2 !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL b2b_end got rv=%0b exp 0", rv2);
        end
        drain();
    endtask

    task automatic test_saturate();
        @(negedge clk);
        clr1 = 1'b1; clr2 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0; clr2 = 1'b0;
        n_cmp = n_cmp + 1;
        if ({ef1, ec1, ef2, ec2} !== 12'h0) begin
            n_err = n_err + 1;
            $display("FAIL clear got ef1=%0b ec1=%0d ef2=%0b ec2=%0d exp all 0", ef1, ec1, ef2, ec2);
        end
        issue(WR, 8'h40, 8'h77);
        issue(WR, 8'h41, 8'h11);
        for (int i = 0; i < 5; i++) issue(RC, 8'h40, 8'h00);
        idle();
        drain();
        n_cmp = n_cmp + 1;
        if ({ec1, ec2, fa2} !== {8'd5, 2'd3, 8'h40}) begin
            n_err = n_err + 1;
            $display("FAIL saturate got ec1=%0d ec2=%0d fa2=%02h exp ec1=5 ec2=3 fa2=40", ec1, ec2, fa2);
        end
        // sixth mismatch lands with clr_err on each instance's retire edge
        issue(RC, 8'h41, 8'h00);
        clr1 = 1'b1;
        idle();
        clr1 = 1'b0;
        @(negedge clk);
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        drain();
        n_cmp = n_cmp + 1;
        if ({ef1, ec1, fa1} !== {1'b1, 8'd1, 8'h41}) begin
            n_err = n_err + 1;
            $display("FAIL clr_vs_fail1 got flag=%0b cnt=%0d fa=%02h exp flag=1 cnt=1 fa=41", ef1, ec1, fa1);
        end
        n_cmp = n_cmp + 1;
        if ({ef2, ec2, fa2} !== {1'b1, 2'd1, 8'h41}) begin
            n_err = n_err + 1;
            $display("FAIL clr_vs_fail2 got flag=%0b cnt=%0d fa=%02h exp flag=1 cnt=1 fa=41", ef2, ec2, fa2);
        end
    endtask

    task automatic test_out_of_range();
        issue(WR, 8'd250, 8'hFF);
        issue(RD, 8'd250, 8'h00);
        issue(RC, 8'd250, 8'h00);
        issue(RD, 8'h10, 8'h00);
        idle();
        drain();
        n_cmp = n_cmp + 1;
        if ({ec1, ec2} !== {8'd2, 2'd1}) begin
            n_err = n_err + 1;
            $display("FAIL oor_cmp got ec1=%0d ec2=%0d exp ec1=2 ec2=1", ec1, ec2);
        end
        n_cmp = n_cmp + 1;
        if ({dout1, dout2} !== 16'h5A5A) begin
            n_err = n_err + 1;
            $display("FAIL oor_no_alias got do1=%02h do2=%02h exp 5a 5a", dout1, dout2);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        issue(RD, 8'h20, 8'h00);
        issue(RD, 8'h10, 8'h00);
        @(negedge clk);
        #1;
        cmd_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (rv1 || rv2) pulses++;
        end
        n_cmp = n_cmp + 1;
        if (pulses != 0) begin
            n_err = n_err + 1;
            $display("FAIL flush got %0d rd_valid pulses exp 0", pulses);
        end
        n_cmp = n_cmp + 1;
        if ({ef1, ec1, ef2, ec2} !== 12'h0) begin
            n_err = n_err + 1;
            $display("FAIL reset_err got ef1=%0b ec1=%0d ef2=%0b ec2=%0d exp all 0", ef1, ec1, ef2, ec2);
        end
        issue(RD, 8'h20, 8'h00);
        idle();
        drain();
        n_cmp = n_cmp + 1;
        if ({dout1, dout2} !== 16'h3333) begin
            n_err = n_err + 1;
            $display("FAIL mem_retained got do1=%02h do2=%02h exp 33 33", dout1, dout2);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_cmp();
        test_back_to_back();
        test_saturate();
        test_out_of_range();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
